bext_sequencer: RTL

Multi-cycle issue/response controller for the B-extension datapath (population count, leading/trailing zero count, carry-less multiply). It sits between the execute-stage dispatch and writeback. It registers one operation, holds operands stable for the programmed number of cycles, captures the result, and presents it on a valid/ready response port. Carry-less multiply is timed as a multicycle path of `CLMUL_LAT` cycles; count operations complete in one cycle.

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/bext_datapath.sv | 100 ++++++++++
 rtl/bext_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared B-extension types: op encoding, sequencer states and the clmul-family predicate.
// The optional carry-less multiplier is selected by the BEXT_CLMUL_EN macro in the users of this package.
package riscv_pkg;

    localparam int XLEN       = 64;
    localparam int BEXT_TAG_W = 5;

    typedef enum logic [3:0] {
        BEXT_CPOP   = 4'd0,
        BEXT_CPOPW  = 4'd1,
        BEXT_CLZ    = 4'd2,
        BEXT_CLZW   = 4'd3,
        BEXT_CTZ    = 4'd4,
        BEXT_CTZW   = 4'd5,
        BEXT_CLMUL  = 4'd6,
        BEXT_CLMULH = 4'd7,
        BEXT_CLMULR = 4'd8
    } bext_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    function automatic logic is_clmul(input bext_op_e op);
        return (op == BEXT_CLMUL) || (op == BEXT_CLMULH) || (op == BEXT_CLMULR);
    endfunction

endpackage

// File: rtl/bext_datapath.sv
// Combinational B-extension datapath: popcount, leading/trailing zero count and carry-less multiply.
// Carry-less multiply hardware exists only when BEXT_CLMUL_EN is defined; otherwise clmul ops flag illegal.
module bext_datapath
    import riscv_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  bext_op_e           op,
    input  logic [WIDTH-1:0]   operand_a,
    input  logic [WIDTH-1:0]   operand_b,
    output logic [WIDTH-1:0]   result,
    output logic               illegal
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    // n selects how many low bits participate, so the W variants share these helpers.
    function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v, input int n);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i < n && v[i]) begin
                c = c + CNT_W'(1);
            end
        end
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] lzc(input logic [WIDTH-1:0] v, input int n);
        logic [CNT_W-1:0] c;
        logic             found;
        c     = CNT_W'(n);
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i < n && !found && v[i]) begin
                c     = CNT_W'(n - 1 - i);
                found = 1'b1;
            end
        end
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] tzc(input logic [WIDTH-1:0] v, input int n);
        logic [CNT_W-1:0] c;
        logic             found;
        c     = CNT_W'(n);
        found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i < n && !found && v[i]) begin
                c     = CNT_W'(i);
                found = 1'b1;
            end
        end
        return c;
    endfunction

    function automatic logic [WIDTH-1:0] widen(input logic [CNT_W-1:0] c);
        return {{(WIDTH - CNT_W){1'b0}}, c};
    endfunction

`ifdef BEXT_CLMUL_EN
    logic [2*WIDTH-1:0] pp [WIDTH];
    logic [2*WIDTH-1:0] product;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp
            assign pp[gi] = operand_b[gi] ? ({{WIDTH{1'b0}}, operand_a} << gi) : '0;
        end
    endgenerate
`else
    logic unused_b;
    assign unused_b = ^operand_b;
`endif

    always_comb begin
        result  = '0;
        illegal = 1'b0;
`ifdef BEXT_CLMUL_EN
        product = '0;
        for (int i = 0; i < WIDTH; i++) begin
            product = product ^ pp[i];
        end
`endif
        case (op)
            BEXT_CPOP:   result = widen(popcount(operand_a, WIDTH));
            BEXT_CPOPW:  result = widen(popcount(operand_a, 32));
            BEXT_CLZ:    result = widen(lzc(operand_a, WIDTH));
            BEXT_CLZW:   result = widen(lzc(operand_a, 32));
            BEXT_CTZ:    result = widen(tzc(operand_a, WIDTH));
            BEXT_CTZW:   result = widen(tzc(operand_a, 32));
`ifdef BEXT_CLMUL_EN
            BEXT_CLMUL:  result = product[WIDTH-1:0];
            BEXT_CLMULH: result = product[2*WIDTH-1:WIDTH];
            BEXT_CLMULR: result = product[2*WIDTH-2:WIDTH-1];
`endif
            default:     illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/bext_sequencer.sv
// Issue/response controller for the B-extension datapath: IDLE -> EXEC (multicycle hold) -> DONE.
// Define BEXT_CLMUL_EN to build the carry-less multiplier; without it clmul ops finish in one cycle as illegal.
module bext_sequencer
    import riscv_pkg::*;
#(
    parameter int WIDTH     = XLEN,
    parameter int CLMUL_LAT = 2,
    parameter int TAG_W     = BEXT_TAG_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  bext_op_e           op_i,
    input  logic [WIDTH-1:0]   operand_a_i,
    input  logic [WIDTH-1:0]   operand_b_i,
    input  logic [TAG_W-1:0]   tag_i,
    input  logic               flush_i,
    output logic               resp_valid_o,
    input  logic               resp_ready_i,
    output logic [WIDTH-1:0]   result_o,
    output logic [TAG_W-1:0]   tag_o,
    output logic               illegal_o,
    output logic               busy_o
);

    // Counter must hold CLMUL_LAT-1 (at most 7).
    localparam int LAT_W = (CLMUL_LAT > 2) ? $clog2(CLMUL_LAT) : 1;

    seq_state_e         state_reg;
    logic [LAT_W-1:0]   cnt_reg;
    bext_op_e           op_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [TAG_W-1:0]   tag_reg;
    logic [WIDTH-1:0]   result_reg;
    logic [TAG_W-1:0]   tag_out_reg;
    logic               illegal_reg;
    logic               resp_valid_reg;

    logic [LAT_W-1:0]   lat_load;
    logic [WIDTH-1:0]   dp_result;
    logic               dp_illegal;
    logic               accept;

`ifdef BEXT_CLMUL_EN
    assign lat_load = is_clmul(op_i) ? LAT_W'(CLMUL_LAT - 1) : '0;
`else
    assign lat_load = '0;
`endif

    // Accepting from DONE on the response handshake edge gives back-to-back issue.
    assign req_ready_o = !flush_i && ((state_reg == ST_IDLE) ||
                                      ((state_reg == ST_DONE) && resp_ready_i));
    assign accept      = req_valid_i && req_ready_o;

    assign resp_valid_o = resp_valid_reg;
    assign result_o     = result_reg;
    assign tag_o        = tag_out_reg;
    assign illegal_o    = illegal_reg;
    assign busy_o       = (state_reg != ST_IDLE);

    bext_datapath #(
        .WIDTH     (WIDTH)
    ) u_datapath (
        .op        (op_reg),
        .operand_a (a_reg),
        .operand_b (b_reg),
        .result    (dp_result),
        .illegal   (dp_illegal)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            op_reg         <= BEXT_CPOP;
            a_reg          <= '0;
            b_reg          <= '0;
            tag_reg        <= '0;
            result_reg     <= '0;
            tag_out_reg    <= '0;
            illegal_reg    <= 1'b0;
            resp_valid_reg <= 1'b0;
        end else if (flush_i) begin
            state_reg      <= ST_IDLE;
            result_reg     <= '0;
            tag_out_reg    <= '0;
            illegal_reg    <= 1'b0;
            resp_valid_reg <= 1'b0;
        end else begin
            if (accept) begin
                op_reg  <= op_i;
                a_reg   <= operand_a_i;
                b_reg   <= operand_b_i;
                tag_reg <= tag_i;
                cnt_reg <= lat_load;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        state_reg <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cnt_reg == '0) begin
                        result_reg     <= dp_result;
                        tag_out_reg    <= tag_reg;
                        illegal_reg    <= dp_illegal;
                        resp_valid_reg <= 1'b1;
                        state_reg      <= ST_DONE;
                    end else begin
                        cnt_reg <= cnt_reg - LAT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (resp_ready_i) begin
                        resp_valid_reg <= 1'b0;
                        state_reg      <= accept ? ST_EXEC : ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
